// File: rtl/n64_vinfo_ext.sv
// n64_vinfo_ext: line counter and PAL/NTSC, 480i/240p classifier fed by the demux sync nibble.
// Latency: all actions take effect on the nDSYNC-low sampling edge itself; vsync_pulse_o is high for exactly one VCLK.
// Backpressure: none; the block follows the fixed 1-in-4 nDSYNC cadence and cannot stall the demux.
//
// Ports:
//   VCLK, RST          video clock, asynchronous active-high reset
//   nDSYNC, Sync_i     sync-nibble strobe (active low) and nibble {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
//   palmode_o          1 = PAL, 0 = NTSC
//   n64_480i_o         1 = interlaced
//   field_o            field id, 0 whenever progressive
//   vsync_pulse_o      one-VCLK pulse per detected field start
//   lines_o            line count of the last completed field
//   locked_o           outputs confirmed by STABLE_FIELDS agreeing fields
module n64_vinfo_ext #(
  parameter int CNT_W         = 10,
  parameter int LINE_THRESH   = 290,
  parameter int STABLE_FIELDS = 2
) (
  input  logic             VCLK,
  input  logic             RST,
  input  logic             nDSYNC,
  input  logic [3:0]       Sync_i,
  output logic             palmode_o,
  output logic             n64_480i_o,
  output logic             field_o,
  output logic             vsync_pulse_o,
  output logic [CNT_W-1:0] lines_o,
  output logic             locked_o
);

  localparam logic [0:0]       S_WAIT_VS = 1'b0;
  localparam logic [0:0]       S_COUNT   = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(LINE_THRESH);
  localparam logic [2:0]       STABLE_N  = 3'(STABLE_FIELDS);

  logic [0:0]       state;
  logic [3:0]       sync_prev;
  logic [CNT_W-1:0] line_cnt;
  logic             prev_cnt_lsb;
  logic             first_field;   // no previous field LSB yet to compare against
  logic             cand_pal;
  logic             cand_i;
  logic [2:0]       stable_cnt;

  logic             hs_fall;
  logic             vs_fall;
  logic             cand_pal_new;
  logic             cand_i_new;
  logic             cand_match;
  logic             commit;
  logic             differs;
  logic             i_next;
  logic [2:0]       stable_nx;
  logic             sync_unused;

  // nCLAMP and nCSYNC are carried in the nibble but play no part in detection.
  assign sync_unused = ^{sync_prev[2], sync_prev[0], Sync_i[2], Sync_i[0]};

  assign hs_fall = sync_prev[1] & ~Sync_i[1];
  assign vs_fall = sync_prev[3] & ~Sync_i[3];

  // Field-end classification and hysteresis, evaluated against the field just closing.
  always_comb begin
    cand_pal_new = 1'b0;
    cand_i_new   = 1'b0;
    cand_match   = 1'b0;
    stable_nx    = 3'd1;
    commit       = 1'b0;
    differs      = 1'b0;
    i_next       = n64_480i_o;

    cand_pal_new = (line_cnt >= THRESH);
    // Interlaced fields alternate between odd and even line counts.
    cand_i_new   = (line_cnt[0] != prev_cnt_lsb);
    cand_match   = ({cand_pal_new, cand_i_new} == {cand_pal, cand_i});
    if (cand_match)
      stable_nx = (stable_cnt >= STABLE_N) ? STABLE_N : stable_cnt + 3'd1;
    commit  = (stable_nx >= STABLE_N);
    differs = ({cand_pal_new, cand_i_new} != {palmode_o, n64_480i_o});
    if (commit)
      i_next = cand_i_new;
  end

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      state         <= S_WAIT_VS;
      sync_prev     <= 4'hF;
      line_cnt      <= '0;
      prev_cnt_lsb  <= 1'b0;
      first_field   <= 1'b0;
      cand_pal      <= 1'b0;
      cand_i        <= 1'b0;
      stable_cnt    <= 3'd0;
      palmode_o     <= 1'b0;
      n64_480i_o    <= 1'b0;
      field_o       <= 1'b0;
      vsync_pulse_o <= 1'b0;
      lines_o       <= '0;
      locked_o      <= 1'b0;
    end else begin
      vsync_pulse_o <= 1'b0;
      if (!nDSYNC) begin
        sync_prev <= Sync_i;
        case (state)
          S_WAIT_VS: begin
            // A coincident hsync is ignored here; counting starts from zero.
            if (vs_fall) begin
              line_cnt      <= '0;
              state         <= S_COUNT;
              first_field   <= 1'b1;
              vsync_pulse_o <= 1'b1;
            end
          end
          S_COUNT: begin
            if (vs_fall) begin
              vsync_pulse_o <= 1'b1;
              lines_o       <= line_cnt;
              prev_cnt_lsb  <= line_cnt[0];
              first_field   <= 1'b0;
              // vsync closes the field; a coincident hsync belongs to the new one.
              line_cnt      <= hs_fall ? CNT_W'(1) : '0;
              if (!first_field) begin
                cand_pal   <= cand_pal_new;
                cand_i     <= cand_i_new;
                stable_cnt <= stable_nx;
                field_o    <= i_next ? line_cnt[0] : 1'b0;
                if (commit) begin
                  palmode_o  <= cand_pal_new;
                  n64_480i_o <= cand_i_new;
                  locked_o   <= 1'b1;
                end else if (!cand_match && differs) begin
                  locked_o <= 1'b0;
                end
              end
            end else if (hs_fall) begin
              if (line_cnt == CNT_MAX - CNT_W'(1)) begin
                // Runaway field: no vsync seen, drop lock and resynchronise.
                line_cnt <= CNT_MAX;
                state    <= S_WAIT_VS;
                locked_o <= 1'b0;
              end else begin
                line_cnt <= line_cnt + CNT_W'(1);
              end
            end
          end
          default: state <= S_WAIT_VS;
        endcase
      end
    end
  end

endmodule
